// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline constants for the hazard control unit: FSM encodings,
// the default mul/div timeout and the wait counter width.
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN         = 2'b00,
        ST_MULDIV_WAIT = 2'b01
    } hcu_state_t;

    localparam int MULDIV_TIMEOUT_DEFAULT = 40;
    localparam int WAIT_CNT_W             = 6;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Load-use hazard detector: flags an ID-stage instruction that reads the
// destination of a load currently in EX. Loads to x0 never create a hazard.
module load_use_detect (
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_use,
    input  logic       id_rs2_use,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_mem_read,
    output logic       hazard
);

    // Compare each used ID source against the EX load destination.
    always_comb begin
        hazard = 1'b0;
        if (ex_mem_read && (ex_rd_addr != 5'd0)) begin
            hazard = (id_rs1_use && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_use && (id_rs2_addr == ex_rd_addr));
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard control unit for a 5-stage pipeline. Produces stall and flush
// controls from data-memory back-pressure, multi-cycle mul/div, taken
// branches and load-use hazards, in that priority. A taken branch that
// meets a higher-priority stall is remembered and flushed exactly once in
// the first unstalled cycle. Stall/flush outputs are combinational from the
// state and the inputs; the state, wait counter, error flag and stall
// counter are registered.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = MULDIV_TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1_ADDR,
    input  logic [4:0]  ID_RS2_ADDR,
    input  logic        ID_RS1_USE,
    input  logic        ID_RS2_USE,
    input  logic [4:0]  EX_RD_ADDR,
    input  logic        EX_MEM_READ,
    input  logic        EX_MULDIV_START,
    input  logic        MULDIV_DONE,
    input  logic        BRANCH_TAKEN,
    input  logic        DMEM_BUSY,
    output logic        PC_STALL,
    output logic        IFID_STALL,
    output logic        IDEX_STALL,
    output logic        EXMEM_STALL,
    output logic        IFID_FLUSH,
    output logic        IDEX_FLUSH,
    output logic        MULDIV_TIMEOUT_ERR,
    output logic [15:0] STALL_CYCLES
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MULDIV_TIMEOUT - 1);

    hcu_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  timeout_err;
    logic [15:0]           stall_cnt;
    logic                  branch_pending;

    logic load_use;
    logic muldiv_stall;
    logic higher_stall;
    logic flush_req;
    logic flush_issue;

    load_use_detect u_load_use_detect (
        .id_rs1_addr (ID_RS1_ADDR),
        .id_rs2_addr (ID_RS2_ADDR),
        .id_rs1_use  (ID_RS1_USE),
        .id_rs2_use  (ID_RS2_USE),
        .ex_rd_addr  (EX_RD_ADDR),
        .ex_mem_read (EX_MEM_READ),
        .hazard      (load_use)
    );

    // Priority resolution of stall/flush controls; reset silences everything.
    always_comb begin
        muldiv_stall = ((state == ST_MULDIV_WAIT) && !MULDIV_DONE) ||
                       ((state == ST_RUN) && EX_MULDIV_START);
        higher_stall = DMEM_BUSY || muldiv_stall;
        flush_req    = BRANCH_TAKEN || branch_pending;
        flush_issue  = 1'b0;
        PC_STALL     = 1'b0;
        IFID_STALL   = 1'b0;
        IDEX_STALL   = 1'b0;
        EXMEM_STALL  = 1'b0;
        IFID_FLUSH   = 1'b0;
        IDEX_FLUSH   = 1'b0;
        if (RESET) begin
            flush_issue = 1'b0;
        end else if (DMEM_BUSY) begin
            PC_STALL    = 1'b1;
            IFID_STALL  = 1'b1;
            IDEX_STALL  = 1'b1;
            EXMEM_STALL = 1'b1;
        end else if (muldiv_stall) begin
            // EX/MEM keeps moving and takes a bubble from the held EX stage.
            PC_STALL   = 1'b1;
            IFID_STALL = 1'b1;
            IDEX_STALL = 1'b1;
        end else if (flush_req) begin
            IFID_FLUSH  = 1'b1;
            IDEX_FLUSH  = 1'b1;
            flush_issue = 1'b1;
        end else if (load_use) begin
            PC_STALL   = 1'b1;
            IFID_STALL = 1'b1;
            IDEX_FLUSH = 1'b1;
        end
    end

    // Mul/div wait FSM with timeout; frozen while data memory is busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (!DMEM_BUSY) begin
            case (state)
                ST_RUN: begin
                    if (EX_MULDIV_START) begin
                        state    <= ST_MULDIV_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MULDIV_WAIT: begin
                    if (MULDIV_DONE) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Remember a taken branch hidden behind a stall until its flush is issued.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            branch_pending <= 1'b0;
        end else if (flush_issue) begin
            branch_pending <= 1'b0;
        end else if (BRANCH_TAKEN && higher_stall) begin
            branch_pending <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (PC_STALL && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign MULDIV_TIMEOUT_ERR = timeout_err;
    assign STALL_CYCLES       = stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit. Each scenario task drives a
// stimulus table, queues the expected stall/flush vector per cycle and
// compares it against the DUT outputs at the falling edge.
module tb_hazard_control_unit;

    logic        CLK;
    logic        RESET;
    logic [4:0]  ID_RS1_ADDR;
    logic [4:0]  ID_RS2_ADDR;
    logic        ID_RS1_USE;
    logic        ID_RS2_USE;
    logic [4:0]  EX_RD_ADDR;
    logic        EX_MEM_READ;
    logic        EX_MULDIV_START;
    logic        MULDIV_DONE;
    logic        BRANCH_TAKEN;
    logic        DMEM_BUSY;
    logic        PC_STALL;
    logic        IFID_STALL;
    logic        IDEX_STALL;
    logic        EXMEM_STALL;
    logic        IFID_FLUSH;
    logic        IDEX_FLUSH;
    logic        MULDIV_TIMEOUT_ERR;
    logic [15:0] STALL_CYCLES;

    // {PC, IFID, IDEX, EXMEM stall, IFID flush, IDEX flush}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_BUSY = 6'b111100;
    localparam logic [5:0] O_MD   = 6'b111000;
    localparam logic [5:0] O_BR   = 6'b000011;
    localparam logic [5:0] O_LU   = 6'b110001;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       st;
        logic       dn;
        logic       br;
        logic       busy;
        logic [5:0] want;
    } stim_t;

    logic [5:0] exp_q[$];
    int         n_vec;
    int         n_miss;

    hazard_control_unit dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .ID_RS1_ADDR        (ID_RS1_ADDR),
        .ID_RS2_ADDR        (ID_RS2_ADDR),
        .ID_RS1_USE         (ID_RS1_USE),
        .ID_RS2_USE         (ID_RS2_USE),
        .EX_RD_ADDR         (EX_RD_ADDR),
        .EX_MEM_READ        (EX_MEM_READ),
        .EX_MULDIV_START    (EX_MULDIV_START),
        .MULDIV_DONE        (MULDIV_DONE),
        .BRANCH_TAKEN       (BRANCH_TAKEN),
        .DMEM_BUSY          (DMEM_BUSY),
        .PC_STALL           (PC_STALL),
        .IFID_STALL         (IFID_STALL),
        .IDEX_STALL         (IDEX_STALL),
        .EXMEM_STALL        (EXMEM_STALL),
        .IFID_FLUSH         (IFID_FLUSH),
        .IDEX_FLUSH         (IDEX_FLUSH),
        .MULDIV_TIMEOUT_ERR (MULDIV_TIMEOUT_ERR),
        .STALL_CYCLES       (STALL_CYCLES)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] obs();
        return {PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, IFID_FLUSH, IDEX_FLUSH};
    endfunction

    function automatic stim_t mk(input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd, input logic mr,
                                 input logic st, input logic dn,
                                 input logic br, input logic busy,
                                 input logic [5:0] want);
        stim_t s;
        s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd; s.mr = mr;
        s.st = st; s.dn = dn; s.br = br; s.busy = busy; s.want = want;
        return s;
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        ID_RS1_ADDR = '0; ID_RS2_ADDR = '0; ID_RS1_USE = 1'b0; ID_RS2_USE = 1'b0;
        EX_RD_ADDR = '0; EX_MEM_READ = 1'b0; EX_MULDIV_START = 1'b0;
        MULDIV_DONE = 1'b0; BRANCH_TAKEN = 1'b0; DMEM_BUSY = 1'b0;
    endtask

    task automatic apply(input stim_t s);
        ID_RS1_ADDR = s.rs1; ID_RS1_USE = s.u1;
        ID_RS2_ADDR = s.rs2; ID_RS2_USE = s.u2;
        EX_RD_ADDR = s.rd; EX_MEM_READ = s.mr;
        EX_MULDIV_START = s.st; MULDIV_DONE = s.dn;
        BRANCH_TAKEN = s.br; DMEM_BUSY = s.busy;
        exp_q.push_back(s.want);
    endtask

    // Leaves the bench 1 time unit after the first post-reset clock edge.
    task automatic do_reset();
        @(posedge CLK); #1;
        clear_inputs();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got, want;
        clear_inputs();
        RESET = 1'b1;
        DMEM_BUSY = 1'b1; BRANCH_TAKEN = 1'b1; EX_MULDIV_START = 1'b1;
        EX_MEM_READ = 1'b1; EX_RD_ADDR = 5'd5; ID_RS1_ADDR = 5'd5; ID_RS1_USE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(O_NONE);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL reset_outputs[%0d] got %b want %b", i, got, want);
            end
        end
        @(posedge CLK); #1;
        n_vec++;
        if (STALL_CYCLES !== 16'd0) begin
            n_miss++; $display("FAIL reset_stall_cycles got %0d want 0", STALL_CYCLES);
        end
        n_vec++;
        if (MULDIV_TIMEOUT_ERR !== 1'b0) begin
            n_miss++; $display("FAIL reset_timeout_err got %b want 0", MULDIV_TIMEOUT_ERR);
        end
        RESET = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        stim_t      t[$];
        logic [5:0] got, want;
        int         exp_stalls;
        do_reset();
        // lw x5 in EX, add x6,x5,x1 in ID; then bubble in EX
        t.push_back(mk(5'd5, 1, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0, O_LU));
        t.push_back(mk(5'd5, 1, 5'd1, 1, 5'd0, 0, 0, 0, 0, 0, O_NONE));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL load_use[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
        n_vec++;
        if (STALL_CYCLES !== 16'd1) begin
            n_miss++; $display("FAIL load_use_count got %0d want 1", STALL_CYCLES);
        end
        exp_stalls = 1;
        t.delete();
        t.push_back(mk(5'd1, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, 0, O_LU));
        t.push_back(mk(5'd1, 1, 5'd7, 0, 5'd7, 1, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(5'd7, 1, 5'd0, 0, 5'd7, 0, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(5'd9, 0, 5'd9, 1, 5'd9, 1, 0, 0, 0, 0, O_LU));
        t.push_back(mk(5'd9, 0, 5'd3, 1, 5'd9, 1, 0, 0, 0, 0, O_NONE));
        exp_stalls += 2;
        for (int i = 0; i < 40; i++) begin
            logic [4:0] rs1, rs2, rd;
            logic       u1, u2, mr, hit;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            hit = mr && (rd != 5'd0) && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
            if (hit) exp_stalls++;
            t.push_back(mk(rs1, u1, rs2, u2, rd, mr, 0, 0, 0, 0, hit ? O_LU : O_NONE));
        end
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL load_use_tbl[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        n_vec++;
        if (STALL_CYCLES !== 16'(exp_stalls)) begin
            n_miss++; $display("FAIL load_use_tbl_count got %0d want %0d", STALL_CYCLES, exp_stalls);
        end
    endtask

    task automatic test_x0_load();
        stim_t      t[$];
        logic [5:0] got, want;
        do_reset();
        t.push_back(mk(5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(5'd0, 1, 5'd3, 1, 5'd0, 1, 0, 0, 0, 0, O_NONE));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL x0_load[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        n_vec++;
        if (STALL_CYCLES !== 16'd0) begin
            n_miss++; $display("FAIL x0_load_count got %0d want 0", STALL_CYCLES);
        end
    endtask

    task automatic test_muldiv();
        stim_t      t[$];
        logic [5:0] got, want;
        do_reset();
        // START held while the op sits in EX, DONE five cycles after START
        for (int i = 0; i < 6; i++)
            t.push_back(mk(0, 0, 0, 0, 0, 0, 1, (i == 5), 0, 0, (i < 5) ? O_MD : O_NONE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        // second op with data memory busy mid-wait: FSM frozen, then DONE
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD));
        for (int i = 0; i < 3; i++)
            t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, O_BUSY));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, O_NONE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL muldiv[%0d] got %b want %b", i, got, want);
            end
            if (i == 6) begin
                n_vec++;
                if (STALL_CYCLES !== 16'd5) begin
                    n_miss++; $display("FAIL muldiv_count got %0d want 5", STALL_CYCLES);
                end
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
        n_vec++;
        if (STALL_CYCLES !== 16'd11) begin
            n_miss++; $display("FAIL muldiv_busy_count got %0d want 11", STALL_CYCLES);
        end
    endtask

    task automatic test_timeout();
        stim_t      t[$];
        logic [5:0] got, want;
        logic [1:0] want_err[$];
        logic       e;
        do_reset();
        // START then 40 non-busy wait cycles, 5 busy cycles inserted after 10
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD)); want_err.push_back(2'b10);
        for (int w = 0; w < 40; w++) begin
            if (w == 10) begin
                for (int b = 0; b < 5; b++) begin
                    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_BUSY)); want_err.push_back(2'b10);
                end
            end
            t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MD)); want_err.push_back(2'b10);
        end
        // back in RUN with the sticky error set
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE)); want_err.push_back(2'b11);
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD));   want_err.push_back(2'b11);
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_MD));   want_err.push_back(2'b11);
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NONE)); want_err.push_back(2'b11);
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE)); want_err.push_back(2'b11);
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL timeout[%0d] got %b want %b", i, got, want);
            end
            e = want_err[i][0]; n_vec++;
            if (MULDIV_TIMEOUT_ERR !== e) begin
                n_miss++; $display("FAIL timeout_err[%0d] got %b want %b", i, MULDIV_TIMEOUT_ERR, e);
            end
            if (i == 46) begin
                n_vec++;
                if (STALL_CYCLES !== 16'd46) begin
                    n_miss++; $display("FAIL timeout_count got %0d want 46", STALL_CYCLES);
                end
            end
            @(posedge CLK); #1;
        end
        do_reset();
        n_vec++;
        if (MULDIV_TIMEOUT_ERR !== 1'b0) begin
            n_miss++; $display("FAIL timeout_err_reset got %b want 0", MULDIV_TIMEOUT_ERR);
        end
    endtask

    task automatic test_branch();
        stim_t      t[$];
        logic [5:0] got, want;
        do_reset();
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        // branch wins over a load-use in the same cycle
        t.push_back(mk(5'd4, 1, 0, 0, 5'd4, 1, 0, 0, 1, 0, O_BR));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        // branch held under busy, still held in the first free cycle
        for (int i = 0; i < 3; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_BUSY));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        // branch dropped when busy ends: the deferred flush still fires once
        for (int i = 0; i < 3; i++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_BUSY));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_BR));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL branch[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
        clear_inputs();
    endtask

    task automatic test_saturation_reset();
        stim_t      t[$];
        logic [5:0] got, want;
        do_reset();
        // preload the counter to 16'hFFFE with back-pressure cycles
        DMEM_BUSY = 1'b1;
        repeat (65534) @(posedge CLK);
        #1;
        DMEM_BUSY = 1'b0;
        n_vec++;
        if (STALL_CYCLES !== 16'hFFFE) begin
            n_miss++; $display("FAIL sat_preload got %h want fffe", STALL_CYCLES);
        end
        for (int i = 0; i < 3; i++) t.push_back(mk(5'd8, 1, 0, 0, 5'd8, 1, 0, 0, 0, 0, O_LU));
        // enter MULDIV_WAIT with a branch deferred behind it
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_MD));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_MD));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, O_MD));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL saturation[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
        n_vec++;
        if (STALL_CYCLES !== 16'hFFFF) begin
            n_miss++; $display("FAIL sat_hold got %h want ffff", STALL_CYCLES);
        end
        // reset in the middle of the wait, branch still asserted
        clear_inputs();
        RESET = 1'b1; BRANCH_TAKEN = 1'b1;
        exp_q.push_back(O_NONE);
        @(negedge CLK);
        got = obs(); want = exp_q.pop_front(); n_vec++;
        if (got !== want) begin
            n_miss++; $display("FAIL midwait_reset_out got %b want %b", got, want);
        end
        @(posedge CLK); #1;
        RESET = 1'b0; BRANCH_TAKEN = 1'b0;
        n_vec++;
        if (STALL_CYCLES !== 16'd0) begin
            n_miss++; $display("FAIL midwait_reset_count got %0d want 0", STALL_CYCLES);
        end
        t.delete();
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge CLK);
            got = obs(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++; $display("FAIL after_reset[%0d] got %b want %b", i, got, want);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_load_use();
        test_x0_load();
        test_muldiv();
        test_timeout();
        test_branch();
        test_saturation_reset();
        if (exp_q.size() != 0) begin
            n_miss++; $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MULDIV_TIMEOUT, default 40, meaning the maximum number of MULDIV_WAIT cycles before a timeout is flagged.
REQ-002 SHALL have ports in this order:
- CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ID_RS1_ADDR, ID_RS2_ADDR  in  5 each  ID-stage source registers.
- ID_RS1_USE, ID_RS2_USE  in  1 each  source actually read.
- EX_RD_ADDR  in  5  EX-stage destination.
- EX_MEM_READ  in  1  EX instruction is a load.
- EX_MULDIV_START  in  1  EX instruction is a multi-cycle M-extension op.
- MULDIV_DONE  in  1  mul/div result valid, 1-cycle pulse.
- BRANCH_TAKEN  in  1  EX resolved a taken branch or jump.
- DMEM_BUSY  in  1  data memory not ready.
- PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL  out  1 each  hold the register.
- IFID_FLUSH, IDEX_FLUSH  out  1 each  load a bubble.
- MULDIV_TIMEOUT_ERR  out  1  sticky timeout flag.
- STALL_CYCLES  out  16  performance counter.

Function
REQ-003 SHALL implement the FSM states RUN and MULDIV_WAIT (2-bit encoding, remaining codes go to RUN).
REQ-004 SHALL decode load-use as EX_MEM_READ && EX_RD_ADDR!=0 && ((ID_RS1_USE && ID_RS1_ADDR==EX_RD_ADDR) || (ID_RS2_USE && ID_RS2_ADDR==EX_RD_ADDR)).
REQ-005 SHALL apply this priority each cycle, with all outputs combinational from the state and the inputs:
- (a) DMEM_BUSY: all four STALL=1, no flush.
- (b) MULDIV stall (state MULDIV_WAIT && !MULDIV_DONE, or state RUN && EX_MULDIV_START): PC/IFID/IDEX_STALL=1, EXMEM_STALL=0, IDEX_FLUSH=0; EX/MEM receives a bubble through the ex stage.
- (c) BRANCH_TAKEN: IFID_FLUSH=1, IDEX_FLUSH=1.
- (d) load-use: PC_STALL=1, IFID_STALL=1, IDEX_FLUSH=1.
- (e) otherwise all outputs 0.
REQ-006 SHALL transition RUN->MULDIV_WAIT when EX_MULDIV_START=1 and DMEM_BUSY=0.
REQ-007 SHALL transition MULDIV_WAIT->RUN on MULDIV_DONE, with the stall released in that same cycle (zero added latency).
REQ-008 SHALL freeze the FSM and the timeout counter while DMEM_BUSY=1.
REQ-009 SHALL, in MULDIV_WAIT, increment a 6-bit wait counter each cycle and clear it on entry to MULDIV_WAIT.
REQ-010 SHALL, on counter==MULDIV_TIMEOUT-1 without MULDIV_DONE, set MULDIV_TIMEOUT_ERR (sticky until RESET) and force the FSM to RUN.
REQ-011 SHALL, when BRANCH_TAKEN coincides with a higher-priority stall, defer the flush: the branch stays held in EX and the flush is issued in the first unstalled cycle, exactly once.
REQ-012 SHALL increment STALL_CYCLES by 1 in every cycle with PC_STALL=1, saturating at 16'hFFFF (no wrap).
REQ-013 SHALL NOT cause a load-use stall when the load writes x0.

Reset
REQ-014 SHALL, on RESET=1 at the rising edge of CLK, set state=RUN, wait counter=0, MULDIV_TIMEOUT_ERR=0 and STALL_CYCLES=0.
REQ-015 SHALL force all stall/flush outputs to 0 while RESET=1.
REQ-016 SHALL, on RESET during MULDIV_WAIT, abandon the wait with no pending flush retained.

Structure
REQ-017 SHALL take the FSM state encodings and the MULDIV_TIMEOUT default from the shared pipeline constants package.
REQ-018 SHALL place load-use detection in one combinational sub-module, load_use_detect (inputs: ID/EX addresses and flags; output: hazard bit).

Verification
REQ-019 Load-use: the bench SHALL drive lw x5 in EX with the ID op add x6,x5,x1 -> one cycle of PC_STALL=IFID_STALL=IDEX_FLUSH=1, then all outputs 0, STALL_CYCLES=1.
REQ-020 x0 load: the bench SHALL drive EX_RD_ADDR=0 with a matching ID_RS1_ADDR=0 -> no stall.
REQ-021 Mul/div: the bench SHALL drive EX_MULDIV_START with MULDIV_DONE 5 cycles later -> stalls high for 5 cycles, low in the DONE cycle, STALL_CYCLES=5.
REQ-022 Timeout: the bench SHALL drive START with DONE never asserted -> MULDIV_TIMEOUT_ERR=1 after 40 cycles, FSM returns to RUN, the error stays set until RESET.
REQ-023 Branch under DMEM_BUSY: the bench SHALL hold BRANCH_TAKEN=1 and DMEM_BUSY=1 for 3 cycles -> no flush for 3 cycles, then a single cycle of IFID_FLUSH=IDEX_FLUSH=1.
REQ-024 Saturation/reset: the bench SHALL preload the counter to 16'hFFFE and apply 3 stall cycles -> counter holds 16'hFFFF; the bench SHALL then assert RESET mid-MULDIV_WAIT -> state RUN, counter 0, all outputs 0.
